// File: rtl/window_gen_5x5.sv
// Streaming 5x5 neighbourhood generator: four line buffers plus a 5x5 shift window, raster-order input.
// Optional macro WIN_CENTER_TAP_EN adds center_pix/center_valid (window centre delayed 3 clocks).
module window_gen_5x5 #(
  parameter int LINE_WIDTH = 640,
  parameter int COL_W      = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [7:0]   pixel_in,
  input  logic         pixel_valid,
  input  logic         sof,
  output logic [199:0] window_out,
  output logic         window_valid
`ifdef WIN_CENTER_TAP_EN
  ,
  output logic [7:0]   center_pix,
  output logic         center_valid
`endif
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
  localparam logic [COL_W-1:0] FIRST_VALID_COL = COL_W'(4);

  logic [COL_W-1:0] r_col_cnt;
  logic [2:0]       r_row_cnt;
  logic [7:0]       r_lb0 [LINE_WIDTH];
  logic [7:0]       r_lb1 [LINE_WIDTH];
  logic [7:0]       r_lb2 [LINE_WIDTH];
  logic [7:0]       r_lb3 [LINE_WIDTH];
  logic [7:0]       r_win [25];
  logic             r_win_valid;

  logic [COL_W-1:0] w_c;
  logic [2:0]       w_row_e;
  logic             w_line_end;
  logic [7:0]       w_col [5];

  // sof restarts row/column context before the current pixel is counted
  assign w_c        = sof ? '0 : r_col_cnt;
  assign w_row_e    = sof ? 3'd0 : r_row_cnt;
  assign w_line_end = (w_c == LAST_COL);

  assign w_col[0] = r_lb3[w_c];
  assign w_col[1] = r_lb2[w_c];
  assign w_col[2] = r_lb1[w_c];
  assign w_col[3] = r_lb0[w_c];
  assign w_col[4] = pixel_in;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_col_cnt   <= '0;
      r_row_cnt   <= 3'd0;
      r_win_valid <= 1'b0;
      for (int k = 0; k < 25; k++) r_win[k] <= 8'h00;
    end else begin
      r_win_valid <= 1'b0;
      if (pixel_valid) begin
        r_col_cnt   <= w_line_end ? '0 : w_c + 1'b1;
        r_row_cnt   <= (w_line_end && (w_row_e != 3'd4)) ? w_row_e + 3'd1 : w_row_e;
        r_win_valid <= (w_row_e == 3'd4) && (w_c >= FIRST_VALID_COL);
        for (int r = 0; r < 5; r++) begin
          for (int j = 0; j < 4; j++) r_win[r*5+j] <= r_win[r*5+j+1];
          r_win[r*5+4] <= w_col[r];
        end
      end
    end
  end

  // Line buffer contents are don't-care after reset, so only writes are gated
  always_ff @(posedge clock) begin
    if (reset_n && pixel_valid) begin
      r_lb3[w_c] <= r_lb2[w_c];
      r_lb2[w_c] <= r_lb1[w_c];
      r_lb1[w_c] <= r_lb0[w_c];
      r_lb0[w_c] <= pixel_in;
    end
  end

  for (genvar k = 0; k < 25; k++) begin : g_pack
    assign window_out[199-8*k -: 8] = r_win[k];
  end

  assign window_valid = r_win_valid;

`ifdef WIN_CENTER_TAP_EN
  // Free-running delay so the tap lines up with the 3-stage Sobel result
  logic [7:0] r_ctr_pix [3];
  logic [2:0] r_ctr_vld;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) r_ctr_pix[k] <= 8'h00;
      r_ctr_vld <= 3'b000;
    end else begin
      r_ctr_pix[0] <= r_win[12];
      r_ctr_pix[1] <= r_ctr_pix[0];
      r_ctr_pix[2] <= r_ctr_pix[1];
      r_ctr_vld    <= {r_ctr_vld[1:0], r_win_valid};
    end
  end

  assign center_pix   = r_ctr_pix[2];
  assign center_valid = r_ctr_vld[2];
`endif

endmodule
